// File: rtl/ecc_scrub_engine.sv
// Background scrubber for port A of the banked ECC memory: reads every location,
// writes the corrected word back, and reports/counts double-bit error locations.
module ecc_scrub_engine #(
    parameter int DATA_A     = 12,
    parameter int MEM_DEPTH  = 64,
    parameter int ADDR_A     = $clog2(4 * MEM_DEPTH),
    parameter int RD_LATENCY = 1,
    parameter int WR_LATENCY = 1,
    parameter int CNT_W      = 8
) (
    input  logic              clka,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_ena,
    output logic              o_wea,
    output logic [ADDR_A-1:0] o_addra,
    output logic [DATA_A-1:0] o_data_a,
    input  logic [DATA_A-1:0] i_dout_a,
    input  logic              i_dbit_err_a,
    output logic              o_err_valid,
    output logic [ADDR_A-1:0] o_err_addr,
    output logic [CNT_W-1:0]  o_err_cnt
);
    localparam int WAIT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [ADDR_A-1:0] LAST_ADDR = ADDR_A'(4 * MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        WR_WAIT  = 3'd4,
        NEXT     = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t              r_state;
    logic [ADDR_A-1:0]   r_addr;
    logic [DATA_A-1:0]   r_wdata;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_busy;
    logic                r_done;
    logic                r_ena;
    logic                r_wea;
    logic                r_err_valid;
    logic [ADDR_A-1:0]   r_err_addr;
    logic [CNT_W-1:0]    r_err_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Scrub sequencer: state, address walk and every registered output.
    always_ff @(posedge clka or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wait      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ena       <= 1'b0;
            r_wea       <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_done      <= 1'b0;
            r_err_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state   <= RD_ISSUE;
                        r_addr    <= '0;
                        r_err_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_ena     <= 1'b1;
                        r_wea     <= 1'b0;
                    end
                end
                RD_ISSUE: begin
                    r_ena   <= 1'b0;
                    r_wait  <= WAIT_W'(RD_LATENCY);
                    r_state <= RD_WAIT;
                end
                RD_WAIT: begin
                    // One cycle beyond the read latency lets the bank mux and decoder settle.
                    if (r_wait == '0) begin
                        if (i_dbit_err_a) begin
                            r_err_valid <= 1'b1;
                            r_err_addr  <= r_addr;
                            r_err_cnt   <= sat_inc(r_err_cnt);
                            r_state     <= NEXT;
                        end else begin
                            r_wdata <= i_dout_a;
                            r_ena   <= 1'b1;
                            r_wea   <= 1'b1;
                            r_state <= WR_ISSUE;
                        end
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                WR_ISSUE: begin
                    r_ena   <= 1'b0;
                    r_wea   <= 1'b0;
                    r_wait  <= WAIT_W'(WR_LATENCY - 1);
                    r_state <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (r_wait == '0) begin
                        r_state <= NEXT;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                NEXT: begin
                    // Pausing only here keeps each read/write-back pair atomic.
                    if (!i_pause) begin
                        if (r_addr == LAST_ADDR) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + ADDR_A'(1);
                            r_ena   <= 1'b1;
                            r_state <= RD_ISSUE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ena   <= 1'b0;
                    r_wea   <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_ena       = r_ena;
    assign o_wea       = r_wea;
    assign o_addra     = r_addr;
    assign o_data_a    = r_wdata;
    assign o_err_valid = r_err_valid;
    assign o_err_addr  = r_err_addr;
    assign o_err_cnt   = r_err_cnt;
endmodule

// File: doc/ecc_scrub_engine.md
Name: ecc_scrub_engine

Overview:
- Single-port initiator that drives port A of the banked ECC memory top.
- Walks every address: reads the location, captures the Hamming-corrected data and the double-bit error flag, then writes the corrected word back so the memory re-encodes it.
- Single-bit upsets are removed before they can accumulate into uncorrectable errors.
- Double-bit error locations are not written back; they are reported and counted for firmware.

Parameters:
- DATA_A, 12, data width of port A (decoded, un-encoded word).
- MEM_DEPTH, 64, depth of one bank; the scrub range is 4*MEM_DEPTH addresses.
- ADDR_A, $clog2(4*MEM_DEPTH), port-A address width.
- RD_LATENCY, 1, read latency of port A in clka cycles (≥1).
- WR_LATENCY, 1, write latency of port A in clka cycles (≥1).
- CNT_W, 8, width of the double-bit error counter.

Ports:
- clka, input, 1, clock; all logic on rising edge.
- i_rst_n, input, 1, reset.
- i_start, input, 1, start a full scrub pass (level sampled in IDLE only).
- i_pause, input, 1, hold scrubbing between locations (host needs port A).
- o_busy, output, 1, high from the first issue until the final NEXT.
- o_done, output, 1, one-cycle pulse at end of pass.
- o_ena, output, 1, port-A enable to the memory top.
- o_wea, output, 1, port-A write enable to the memory top.
- o_addra, output, ADDR_A, port-A address.
- o_data_a, output, DATA_A, write-back data.
- i_dout_a, input, DATA_A, corrected read data from the memory top.
- i_dbit_err_a, input, 1, double-bit error flag from the memory top.
- o_err_valid, output, 1, one-cycle pulse per double-bit error found.
- o_err_addr, output, ADDR_A, address of the most recent double-bit error.
- o_err_cnt, output, CNT_W, double-bit errors found in the current/last pass.

Interface (already decided):
- One clock (clka).
- Reset i_rst_n is asynchronous, active-low.

Behaviour:
- Reset: state=IDLE. Every output is 0: o_busy, o_done, o_ena, o_wea, o_addra, o_data_a, o_err_valid, o_err_addr, o_err_cnt.
  - Reset mid-pass aborts immediately; no partial write is completed.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, NEXT, DONE.
- IDLE:
  - i_start=1 → RD_ISSUE with addr=0, o_err_cnt cleared to 0.
  - i_start is ignored in every other state.
- RD_ISSUE (1 cycle): o_ena=1, o_wea=0, o_addra=addr → RD_WAIT.
- RD_WAIT:
  - Lasts RD_LATENCY+1 cycles; the extra cycle covers mux and decoder settle. o_ena=0.
  - On the last RD_WAIT edge, capture i_dout_a into a data register and sample i_dbit_err_a.
  - i_dbit_err_a=1: o_err_valid pulses the next cycle, o_err_addr=addr, o_err_cnt+=1 (saturates at 2^CNT_W-1), then go directly to NEXT (no write-back).
  - Otherwise → WR_ISSUE.
- WR_ISSUE (1 cycle): o_ena=1, o_wea=1, o_addra=addr, o_data_a=captured data → WR_WAIT.
- WR_WAIT: WR_LATENCY cycles with o_ena=0 → NEXT.
- NEXT:
  - i_pause=1: hold in NEXT with o_ena=0, o_busy=1.
  - Else, if addr == 4*MEM_DEPTH-1 → DONE.
  - Else addr+=1 → RD_ISSUE.
- DONE (1 cycle): o_done=1, o_busy=0 → IDLE.
  - The address does not wrap into a second pass; a new i_start is required.
- o_busy: 0 only in IDLE and DONE.
- o_ena and o_wea are deasserted outside the ISSUE states, so the host may use port A whenever the engine is in NEXT with i_pause=1.
- o_data_a and o_addra hold their last values outside the ISSUE states.
- Timing with defaults: a clean location takes 6 cycles; a double-bit location takes 4 cycles.
- i_pause is honoured only in NEXT. A read-write pair on one location is never split.

Test Plan:
- Reset then i_start pulse, all locations clean: o_ena asserts for 512 cycles total (256 reads + 256 writes); each write data equals the prior read data; o_done pulses at cycle 1+256*6; o_err_cnt=0.
- Preload addr 0x2A with a single-bit flipped codeword: write-back at 0x2A carries the corrected data. A later read of 0x2A shows a clean codeword with i_dbit_err_a=0.
- Force i_dbit_err_a=1 when addr 0x10 is read: no write issued at 0x10; o_err_valid pulses once; o_err_addr=0x10; o_err_cnt=1; pass length is 2 cycles shorter.
- Hold i_pause=1 for 20 cycles starting while in RD_WAIT of addr 5: write to 5 completes; the engine stalls in NEXT with o_ena=0 for the pause; addr 6 read issues 1 cycle after i_pause drops.
- Assert i_rst_n=0 during WR_WAIT of addr 100: all outputs are 0 asynchronously; after release, i_start restarts at addr 0 with o_err_cnt=0.
- i_start held high through an entire pass: exactly one o_done pulse; a second pass begins the cycle after returning to IDLE. With CNT_W=2 and 5 forced double-bit errors, o_err_cnt saturates at 3.
